// File: rtl/program_loader_pkg.sv
// Shared definitions for the program-memory loader and the instruction decoder.
// The CHECK state exists only when LOADER_CHECKSUM_EN is defined.
package program_loader_pkg;

  typedef enum logic [2:0] {
    ST_LOW   = 3'd0,
    ST_HIGH  = 3'd1,
    ST_WRITE = 3'd2,
`ifdef LOADER_CHECKSUM_EN
    ST_CHECK = 3'd3,
`endif
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } state_t;

  localparam logic [4:0] OPC_HALT = 5'b00000;

endpackage

// File: rtl/program_loader.sv
// Fills program memory from a byte stream (low byte first) while holding the CPU in reset.
// Optional LOADER_CHECKSUM_EN macro adds a trailing XOR checksum byte check before release.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int NBITS_0 = 11,
  parameter int NBITS_D = 16,
  parameter int OPCODE  = 5,
  parameter int NBYTE   = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NBYTE-1:0]   i_RxData,
  input  logic               i_RxDone,
  input  logic               i_Reload,
  output logic [NBITS_0-1:0] o_WrAddr,
  output logic [NBITS_D-1:0] o_WrData,
  output logic               o_WrEn,
  output logic               o_CpuReset,
  output logic               o_Done,
  output logic               o_Error
);

  state_t               state_q, state_d;
  logic [NBITS_0-1:0]   addr_q, addr_d;
  logic [NBITS_D-1:0]   data_q, data_d;
  logic                 cpu_rst_q, cpu_rst_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;
  logic                 is_halt;
  logic                 addr_full;
`ifdef LOADER_CHECKSUM_EN
  logic [NBYTE-1:0]     csum_q, csum_d;
`endif

  assign is_halt   = (data_q[NBITS_D-1 -: OPCODE] == OPCODE'(OPC_HALT));
  assign addr_full = (addr_q == {NBITS_0{1'b1}});

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    cpu_rst_d = cpu_rst_q;
    done_d    = done_q;
    error_d   = error_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    case (state_q)
      ST_LOW: begin
        if (i_RxDone) begin
          data_d[NBYTE-1:0] = i_RxData;
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_q ^ i_RxData;
`endif
          state_d = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (i_RxDone) begin
          data_d[NBITS_D-1 -: NBYTE] = i_RxData;
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_q ^ i_RxData;
`endif
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (is_halt) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = ST_CHECK;
`else
          state_d   = ST_DONE;
          cpu_rst_d = 1'b0;
          done_d    = 1'b1;
`endif
        end else if (addr_full) begin
          state_d = ST_ERROR;
          error_d = 1'b1;
        end else begin
          addr_d = addr_q + 1'b1;
          // A byte arriving during the write strobe is the next low byte.
          if (i_RxDone) begin
            data_d[NBYTE-1:0] = i_RxData;
`ifdef LOADER_CHECKSUM_EN
            csum_d = csum_q ^ i_RxData;
`endif
            state_d = ST_HIGH;
          end else begin
            state_d = ST_LOW;
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (i_RxDone) begin
          if (i_RxData == csum_q) begin
            state_d   = ST_DONE;
            cpu_rst_d = 1'b0;
            done_d    = 1'b1;
          end else begin
            state_d = ST_ERROR;
            error_d = 1'b1;
          end
        end
      end
`endif
      ST_DONE, ST_ERROR: begin
        if (i_Reload) begin
          state_d   = ST_LOW;
          addr_d    = '0;
          cpu_rst_d = 1'b1;
          done_d    = 1'b0;
          error_d   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
          csum_d    = '0;
`endif
        end
      end
      default: begin
        state_d = ST_LOW;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= ST_LOW;
      addr_q    <= '0;
      data_q    <= '0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      cpu_rst_q <= cpu_rst_d;
      done_q    <= done_d;
      error_q   <= error_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

  assign o_WrAddr   = addr_q;
  assign o_WrData   = data_q;
  assign o_WrEn     = (state_q == ST_WRITE);
  assign o_CpuReset = cpu_rst_q;
  assign o_Done     = done_q;
  assign o_Error    = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: load, back-to-back bytes, overflow, reset, reload
// and, with LOADER_CHECKSUM_EN defined, the checksum accept/reject paths.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic        reload;
  logic [10:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_en;
  logic        cpu_reset;
  logic        done;
  logic        error;

  int n_vec = 0;
  int n_err = 0;
  int wr_cnt = 0;

  program_loader dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_RxData   (rx_data),
    .i_RxDone   (rx_done),
    .i_Reload   (reload),
    .o_WrAddr   (wr_addr),
    .o_WrData   (wr_data),
    .o_WrEn     (wr_en),
    .o_CpuReset (cpu_reset),
    .o_Done     (done),
    .o_Error    (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr_en === 1'b1) wr_cnt <= wr_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Called at a negedge; strobes one byte and returns at the following negedge.
  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  int base;

  initial begin
    rst = 1'b1; rx_data = 8'h00; rx_done = 1'b0; reload = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_val("rst_addr",  32'(wr_addr),   32'h0);
    check_val("rst_data",  32'(wr_data),   32'h0);
    check_val("rst_wren",  32'(wr_en),     32'h0);
    check_val("rst_cpu",   32'(cpu_reset), 32'h1);
    check_val("rst_done",  32'(done),      32'h0);
    check_val("rst_err",   32'(error),     32'h0);

    // Two-word program ending in HALT
    send_byte(8'h05);
    send_byte(8'h08);
    check_val("w0_en",   32'(wr_en),   32'h1);
    check_val("w0_addr", 32'(wr_addr), 32'h0);
    check_val("w0_data", 32'(wr_data), 32'h0805);
    @(negedge clk);
    check_val("w0_en_off", 32'(wr_en), 32'h0);
    send_byte(8'h00);
    send_byte(8'h00);
    check_val("halt_en",   32'(wr_en),     32'h1);
    check_val("halt_addr", 32'(wr_addr),   32'h1);
    check_val("halt_data", 32'(wr_data),   32'h0000);
    check_val("halt_cpu",  32'(cpu_reset), 32'h1);
    check_val("halt_done", 32'(done),      32'h0);
    @(negedge clk);
`ifdef LOADER_CHECKSUM_EN
    check_val("chk_wait_done", 32'(done),      32'h0);
    check_val("chk_wait_cpu",  32'(cpu_reset), 32'h1);
    send_byte(8'h0D);
`endif
    check_val("p1_done", 32'(done),      32'h1);
    check_val("p1_cpu",  32'(cpu_reset), 32'h0);
    check_val("p1_addr", 32'(wr_addr),   32'h1);

    // Bytes after DONE are ignored
    base = wr_cnt;
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    @(negedge clk);
    check_val("done_nowr",  32'(wr_cnt - base), 32'h0);
    check_val("done_stays", 32'(done),          32'h1);

    // Reload, then a byte arriving in the WRITE cycle
    pulse_reload();
    check_val("rl_addr", 32'(wr_addr),   32'h0);
    check_val("rl_cpu",  32'(cpu_reset), 32'h1);
    check_val("rl_done", 32'(done),      32'h0);
    send_byte(8'hFF);
    send_byte(8'hFF);
    check_val("bb0_en",   32'(wr_en),   32'h1);
    check_val("bb0_data", 32'(wr_data), 32'hFFFF);
    send_byte(8'h34);
    send_byte(8'h12);
    check_val("bb1_en",   32'(wr_en),   32'h1);
    check_val("bb1_addr", 32'(wr_addr), 32'h1);
    check_val("bb1_data", 32'(wr_data), 32'h1234);
    @(negedge clk);
    // Reload is ignored while loading
    pulse_reload();
    send_byte(8'h00);
    send_byte(8'h00);
    check_val("bb2_addr", 32'(wr_addr), 32'h2);
    @(negedge clk);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h34 ^ 8'h12);
`endif
    check_val("bb_done", 32'(done), 32'h1);

    // Reset in the middle of word 3
    pulse_reload();
    send_byte(8'h01); send_byte(8'h08); @(negedge clk);
    send_byte(8'h02); send_byte(8'h08); @(negedge clk);
    send_byte(8'h03); send_byte(8'h08); @(negedge clk);
    check_val("mid_addr", 32'(wr_addr), 32'h3);
    send_byte(8'h04);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("mr_addr", 32'(wr_addr),   32'h0);
    check_val("mr_data", 32'(wr_data),   32'h0);
    check_val("mr_wren", 32'(wr_en),     32'h0);
    check_val("mr_cpu",  32'(cpu_reset), 32'h1);
    check_val("mr_done", 32'(done),      32'h0);
    send_byte(8'hAA);
    send_byte(8'h00);
    check_val("mr_w_en",   32'(wr_en),   32'h1);
    check_val("mr_w_addr", 32'(wr_addr), 32'h0);
    check_val("mr_w_data", 32'(wr_data), 32'h00AA);
    @(negedge clk);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'hAA);
`endif
    check_val("mr_done2", 32'(done), 32'h1);

    // Overflow: 2048 non-HALT words back to back
    pulse_reload();
    base = wr_cnt;
    for (int i = 0; i < 2048; i++) begin
      send_byte(8'hFF);
      send_byte(8'hFF);
    end
    check_val("ov_last_en",   32'(wr_en),   32'h1);
    check_val("ov_last_addr", 32'(wr_addr), 32'h7FF);
    @(negedge clk);
    check_val("ov_count", 32'(wr_cnt - base), 32'd2048);
    check_val("ov_err",   32'(error),          32'h1);
    check_val("ov_cpu",   32'(cpu_reset),      32'h1);
    check_val("ov_done",  32'(done),           32'h0);
    check_val("ov_addr",  32'(wr_addr),        32'h7FF);
    base = wr_cnt;
    send_byte(8'h00);
    send_byte(8'h00);
    @(negedge clk);
    check_val("err_nowr", 32'(wr_cnt - base), 32'h0);
    pulse_reload();
    check_val("erl_err",  32'(error),     32'h0);
    check_val("erl_addr", 32'(wr_addr),   32'h0);
    check_val("erl_cpu",  32'(cpu_reset), 32'h1);
    send_byte(8'h00);
    send_byte(8'h00);
    check_val("erl_w_addr", 32'(wr_addr), 32'h0);
    @(negedge clk);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h00);
`endif
    check_val("erl_done", 32'(done), 32'h1);

`ifdef LOADER_CHECKSUM_EN
    // Wrong checksum byte
    pulse_reload();
    send_byte(8'h05); send_byte(8'h08); @(negedge clk);
    send_byte(8'h00); send_byte(8'h00); @(negedge clk);
    send_byte(8'h0C);
    check_val("cs_bad_err",  32'(error),     32'h1);
    check_val("cs_bad_done", 32'(done),      32'h0);
    check_val("cs_bad_cpu",  32'(cpu_reset), 32'h1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
